load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
- Initiator side of the data bus. Accepts one load or store per handshake from the core execute stage.
- Checks funct3 and alignment, then drives one read or write strobe into the data bus controller's wd/rd/size/addr/data interface.
- Sign- or zero-extends load data and returns a single-cycle response carrying data and an error code.
- Sits between the core pipeline and the data bus controller; one outstanding request at a time.

Parameters:
TIMEOUT_CYCLES, 16, max cycles waiting in ISSUE for bus_ready & !bus_busy before reporting timeout (LSU_TIMEOUT_EN only)
TMO_W, 5, width of timeout counter; must hold TIMEOUT_CYCLES

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
req_valid  input  1  core presents a request
req_ready  output  1  LSU can accept; high only in IDLE
req_we  input  1  1 = store, 0 = load
req_funct3  input  3  RV32I funct3 (LB 000, LH 001, LW 010, LBU 100, LHU 101; stores 000/001/010)
req_addr  input  32  byte address
req_wdata  input  32  store data, low-aligned
resp_valid  output  1  one-cycle pulse, response valid
resp_rdata  output  32  extended load data; 0 for stores and errors
resp_err  output  2  00 ok, 01 misaligned, 10 timeout, 11 illegal funct3
bus_wd  output  1  write strobe to controller wd
bus_rd  output  1  read strobe to controller rd
bus_size_in  output  2  write size (00 byte, 01 half, 10 word)
bus_size_out  output  2  read size
bus_addr_in  output  32  write address
bus_addr_out  output  32  read address
bus_wdata  output  32  write data, to controller data_in
bus_rdata  input  32  read data, from controller data_out
bus_ready  input  1  controller ready
bus_busy  input  1  controller busy

Behaviour:
- Reset: async to IDLE. req_ready=1; all other outputs 0; latched request cleared; timeout counter 0.
- States and transitions:
  - IDLE: on req_valid & req_ready, latch we/funct3/addr/wdata.
    - Illegal funct3 (load 011/110/111; store funct3 > 010) -> RESP with err 11.
    - Misaligned (word with addr[1:0] != 0; half with addr[0] != 0) -> RESP with err 01.
    - Otherwise -> ISSUE.
  - ISSUE: strobes asserted only in a cycle where bus_ready & !bus_busy; that cycle is the single strobe cycle, then -> RESP. Otherwise stay with strobes low.
  - RESP: resp_valid=1 for exactly one cycle -> IDLE. No back-pressure on responses.
- No bus strobe for any error path.
- Bus drive: strobes, sizes, addresses and bus_wdata are decoded combinationally from state and latched request. Consequently an async reset mid-ISSUE drops every strobe immediately and no response is produced.
  - Store: bus_wd=1, bus_size_in = size, bus_addr_in = addr, bus_wdata = wdata masked to size (upper bits 0).
  - Load: bus_rd=1, bus_size_out = size, bus_addr_out = addr.
  - Unused address/size/data outputs are held at 0.
- Load data: bus_rdata is sampled on the clock edge ending the strobe cycle.
  - LB/LH: sign-extend bit 7 / bit 15.
  - LBU/LHU: zero-extend.
  - LW: pass through.
- Latency with an idle bus: accept edge at cycle 0, strobe in cycle 1, resp_valid in cycle 2. Error responses: resp_valid in cycle 1.
- req_valid while not IDLE is ignored (req_ready=0).

Optional Feature:
LSU_TIMEOUT_EN
- Defined:
  - The counter increments each ISSUE cycle in which the bus is unavailable.
  - When it reaches TIMEOUT_CYCLES, the FSM goes to RESP with err 10 and no strobe.
  - The counter clears on entry to ISSUE.
- Undefined: the counter is absent, ISSUE waits indefinitely, and err 10 is never produced.

Decomposition:
- Shared header LoadStore.vh: funct3 codes, size codes (SIZE_BYTE/HALF/WORD), error codes, FSM state encodings.
- One natural sub-module: load_extend, a combinational funct3-driven sign/zero extension of bus_rdata, reusable by the core's future cache path.

Test Plan:
- LW addr 0x0000_0010, bus idle, bus_rdata 0x8123_4567 -> bus_rd high exactly cycle 1 with bus_size_out 10; cycle 2 resp_valid=1, resp_rdata 0x8123_4567, err 00.
- LB and LBU at 0x13 with bus_rdata 0x0000_0080 -> resp_rdata 0xFFFF_FF80 (LB) and 0x0000_0080 (LBU).
- SH addr 0x22, wdata 0xDEAD_BEEF -> bus_wd one cycle, bus_size_in 01, bus_addr_in 0x22, bus_wdata 0x0000_BEEF; resp err 00.
- LW at 0x0000_0006, then SH at 0x0000_0003 -> each returns resp_valid in cycle 1 with err 01; bus_rd/bus_wd never asserted.
- bus_busy held high 20 cycles with LSU_TIMEOUT_EN, TIMEOUT_CYCLES=16 -> resp err 10 after 16 ISSUE cycles, no strobe. Without the macro -> strobe in the first cycle busy falls.
- rst pulsed during ISSUE with bus_busy high -> outputs 0 immediately, req_ready=1, no resp_valid; next request completes normally.

Source files
------------

// File: rtl/load_store_unit_pkg.sv
// load_store_unit_pkg: shared encodings for the load/store unit.
// funct3 codes, bus size codes, response error codes, FSM states, the latched
// request payload and small decode helpers used by load_store_unit and load_extend.
package load_store_unit_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned F3_W   = 3;

  // RV32I load/store funct3 codes
  localparam logic [F3_W-1:0] F3_LB  = 3'b000;
  localparam logic [F3_W-1:0] F3_LH  = 3'b001;
  localparam logic [F3_W-1:0] F3_LW  = 3'b010;
  localparam logic [F3_W-1:0] F3_LBU = 3'b100;
  localparam logic [F3_W-1:0] F3_LHU = 3'b101;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'b00,
    SIZE_HALF = 2'b01,
    SIZE_WORD = 2'b10
  } size_e;

  typedef enum logic [1:0] {
    ERR_OK       = 2'b00,
    ERR_MISALIGN = 2'b01,
    ERR_TIMEOUT  = 2'b10,
    ERR_ILLEGAL  = 2'b11
  } err_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_ISSUE = 2'b01,
    S_RESP  = 2'b10
  } state_e;

  typedef struct packed {
    logic              we;
    logic [F3_W-1:0]   funct3;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } lsu_req_t;

  // Stores only allow 000/001/010; loads reject 011/110/111.
  function automatic logic f3_legal(input logic we, input logic [F3_W-1:0] f3);
    if (we) return (f3 <= F3_LW);
    return (f3 != 3'b011) && (f3 != 3'b110) && (f3 != 3'b111);
  endfunction

  // Access size lives in funct3[1:0] for every legal code.
  function automatic size_e f3_size(input logic [F3_W-1:0] f3);
    return size_e'(f3[1:0]);
  endfunction

  function automatic logic is_misaligned(input size_e size, input logic [1:0] lsb);
    return ((size == SIZE_WORD) && (lsb != 2'b00)) ||
           ((size == SIZE_HALF) && lsb[0]);
  endfunction

  // Store data is low-aligned; bits above the access size are forced to 0.
  function automatic logic [DATA_W-1:0] mask_wdata(input size_e size,
                                                   input logic [DATA_W-1:0] d);
    case (size)
      SIZE_BYTE: return {24'h0, d[7:0]};
      SIZE_HALF: return {16'h0, d[15:0]};
      default:   return d;
    endcase
  endfunction

endpackage

// File: rtl/load_store_unit_extend.sv
// load_extend: combinational funct3-driven sign/zero extension of read data.
// Ports: funct3 (load funct3), data (raw bus read data), rdata_ext_c (extended data).
module load_extend
  import load_store_unit_pkg::*;
(
  input  logic [F3_W-1:0]   funct3,
  input  logic [DATA_W-1:0] data,
  output logic [DATA_W-1:0] rdata_ext_c
);

  always_comb begin
    rdata_ext_c = data;
    case (funct3)
      F3_LB:   rdata_ext_c = {{24{data[7]}}, data[7:0]};
      F3_LH:   rdata_ext_c = {{16{data[15]}}, data[15:0]};
      F3_LBU:  rdata_ext_c = {24'h0, data[7:0]};
      F3_LHU:  rdata_ext_c = {16'h0, data[15:0]};
      default: rdata_ext_c = data;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: data-bus initiator for core loads/stores, one request at a time.
// Core side : req_valid/req_ready/req_we/req_funct3/req_addr/req_wdata in,
//             resp_valid/resp_rdata/resp_err out (single-cycle response pulse).
// Bus side  : bus_wd/bus_rd strobes with size/addr/wdata, bus_rdata/bus_ready/bus_busy in.
// Bus outputs are decoded combinationally from state and the latched request.
// Optional macro LSU_TIMEOUT_EN: abort ISSUE with err 10 after TIMEOUT_CYCLES
// unavailable-bus cycles; without it ISSUE waits indefinitely.
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter int unsigned TMO_W          = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [F3_W-1:0]   req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic [1:0]        resp_err,
  output logic              bus_wd,
  output logic              bus_rd,
  output logic [1:0]        bus_size_in,
  output logic [1:0]        bus_size_out,
  output logic [ADDR_W-1:0] bus_addr_in,
  output logic [ADDR_W-1:0] bus_addr_out,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic [DATA_W-1:0] bus_rdata,
  input  logic              bus_ready,
  input  logic              bus_busy
);

  // Counter must be able to reach TIMEOUT_CYCLES.
  if ((TIMEOUT_CYCLES == 0) || (TIMEOUT_CYCLES >= (1 << TMO_W))) begin : g_tmo_cfg_bad
    $error("load_store_unit: TMO_W too narrow for TIMEOUT_CYCLES");
  end

  state_e            state_q, state_d;
  lsu_req_t          req_q, req_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  err_e              err_q, err_d;

  logic              bus_ok_c;
  logic              strobe_c;
  size_e             size_c;
  logic [DATA_W-1:0] ext_c;

  assign bus_ok_c = bus_ready & ~bus_busy;
  assign strobe_c = (state_q == S_ISSUE) && bus_ok_c;
  assign size_c   = f3_size(req_q.funct3);

  load_extend u_load_extend (
    .funct3      (req_q.funct3),
    .data        (bus_rdata),
    .rdata_ext_c (ext_c)
  );

`ifdef LSU_TIMEOUT_EN
  logic [TMO_W-1:0] tmo_q, tmo_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) tmo_q <= '0;
    else     tmo_q <= tmo_d;
  end
`endif

  // State and request registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      req_q   <= '0;
      rdata_q <= '0;
      err_q   <= ERR_OK;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Next-state: accept/check in IDLE, wait for bus in ISSUE, one-cycle RESP
  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    rdata_d = rdata_q;
    err_d   = err_q;
`ifdef LSU_TIMEOUT_EN
    tmo_d   = tmo_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          req_d   = '{we: req_we, funct3: req_funct3, addr: req_addr, wdata: req_wdata};
          rdata_d = '0;
          if (!f3_legal(req_we, req_funct3)) begin
            err_d   = ERR_ILLEGAL;
            state_d = S_RESP;
          end else if (is_misaligned(f3_size(req_funct3), req_addr[1:0])) begin
            err_d   = ERR_MISALIGN;
            state_d = S_RESP;
          end else begin
            err_d   = ERR_OK;
            state_d = S_ISSUE;
`ifdef LSU_TIMEOUT_EN
            tmo_d   = '0;
`endif
          end
        end
      end
      S_ISSUE: begin
        if (bus_ok_c) begin
          state_d = S_RESP;
          if (!req_q.we) rdata_d = ext_c;
        end
`ifdef LSU_TIMEOUT_EN
        // tmo_q counts prior unavailable cycles; this one makes TIMEOUT_CYCLES.
        else if (tmo_q >= TMO_W'(TIMEOUT_CYCLES - 1)) begin
          err_d   = ERR_TIMEOUT;
          state_d = S_RESP;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
`endif
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Bus drive: only the active direction carries non-zero fields
  always_comb begin
    bus_wd       = 1'b0;
    bus_rd       = 1'b0;
    bus_size_in  = 2'b00;
    bus_size_out = 2'b00;
    bus_addr_in  = '0;
    bus_addr_out = '0;
    bus_wdata    = '0;
    if (strobe_c) begin
      if (req_q.we) begin
        bus_wd      = 1'b1;
        bus_size_in = size_c;
        bus_addr_in = req_q.addr;
        bus_wdata   = mask_wdata(size_c, req_q.wdata);
      end else begin
        bus_rd       = 1'b1;
        bus_size_out = size_c;
        bus_addr_out = req_q.addr;
      end
    end
  end

  assign req_ready  = (state_q == S_IDLE);
  assign resp_valid = (state_q == S_RESP);
  assign resp_rdata = resp_valid ? rdata_q : '0;
  assign resp_err   = resp_valid ? err_q : ERR_OK;

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: scoreboard bench for load_store_unit.
// Expected responses are queued when a request is driven and popped by a
// response monitor; strobe timing and bus fields are checked per cycle.
module tb_load_store_unit;

  localparam int unsigned TMO = 16;

  typedef struct packed {
    logic [31:0] rdata;
    logic [1:0]  err;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic [1:0]  resp_err;
  logic        bus_wd, bus_rd;
  logic [1:0]  bus_size_in, bus_size_out;
  logic [31:0] bus_addr_in, bus_addr_out, bus_wdata, bus_rdata;
  logic        bus_ready, bus_busy;

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  load_store_unit #(.TIMEOUT_CYCLES(TMO), .TMO_W(5)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .bus_wd(bus_wd), .bus_rd(bus_rd),
    .bus_size_in(bus_size_in), .bus_size_out(bus_size_out),
    .bus_addr_in(bus_addr_in), .bus_addr_out(bus_addr_out),
    .bus_wdata(bus_wdata), .bus_rdata(bus_rdata),
    .bus_ready(bus_ready), .bus_busy(bus_busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [1:0] model_err(input logic we, input logic [2:0] f3,
                                           input logic [31:0] addr);
    logic legal;
    legal = we ? (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2)
               : (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd5);
    if (!legal) return 2'b11;
    if (f3[1:0] == 2'b10 && addr[1:0] != 2'b00) return 2'b01;
    if (f3[1:0] == 2'b01 && addr[0]) return 2'b01;
    return 2'b00;
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] r);
    case (f3)
      3'd0:    return {{24{r[7]}}, r[7:0]};
      3'd1:    return {{16{r[15]}}, r[15:0]};
      3'd4:    return {24'h0, r[7:0]};
      3'd5:    return {16'h0, r[15:0]};
      default: return r;
    endcase
  endfunction

  function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] w);
    case (f3[1:0])
      2'b00:   return w & 32'h0000_00FF;
      2'b01:   return w & 32'h0000_FFFF;
      default: return w;
    endcase
  endfunction

  task automatic set_bus(input logic unavail, input logic via_ready);
    if (!unavail)       begin bus_ready = 1'b1; bus_busy = 1'b0; end
    else if (via_ready) begin bus_ready = 1'b0; bus_busy = 1'b0; end
    else                begin bus_ready = 1'b1; bus_busy = 1'b1; end
  endtask

  // Response monitor: every resp_valid pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (resp_valid === 1'b1) begin
      if (sb.size() == 0) begin
        check("resp_unexpected", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("resp_rdata", resp_rdata, e.rdata);
        check("resp_err", 32'(resp_err), 32'(e.err));
      end
    end
  end

  // Drive one request; bus unavailable for busy_n cycles after acceptance.
  task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] rdata,
                        input int busy_n, input logic via_ready);
    logic [1:0] e;
    int strobe_exp, resp_exp, strobe_cyc, resp_cyc, nstrobe;
    exp_t x;
    e = model_err(we, f3, addr);
`ifdef LSU_TIMEOUT_EN
    if (e == 2'b00 && busy_n >= int'(TMO)) e = 2'b10;
`endif
    strobe_exp = (e == 2'b00) ? busy_n + 1 : -1;
    resp_exp   = (e == 2'b00) ? busy_n + 2 : (e == 2'b10) ? int'(TMO) + 1 : 1;
    x.rdata = (e == 2'b00 && !we) ? model_load(f3, rdata) : 32'h0;
    x.err   = e;
    sb.push_back(x);

    @(posedge clk); #1;
    req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
    req_valid = 1'b1; bus_rdata = rdata;
    set_bus(busy_n > 0, via_ready);
    @(posedge clk); #1;
    req_valid = 1'b0;
    strobe_cyc = -1; resp_cyc = -1; nstrobe = 0;
    for (int k = 1; k <= 60 && resp_cyc < 0; k++) begin
      set_bus(k <= busy_n, via_ready);
      @(negedge clk);
      check("req_ready_busy", 32'(req_ready), 32'd0);
      if (resp_valid) resp_cyc = k;
      if (bus_wd || bus_rd) begin
        nstrobe++;
        strobe_cyc = k;
        check("strobe_wd", 32'(bus_wd), 32'(we));
        check("strobe_rd", 32'(bus_rd), 32'(!we));
        check("size_in", 32'(bus_size_in), we ? 32'(f3[1:0]) : 32'd0);
        check("size_out", 32'(bus_size_out), we ? 32'd0 : 32'(f3[1:0]));
        check("addr_in", bus_addr_in, we ? addr : 32'h0);
        check("addr_out", bus_addr_out, we ? 32'h0 : addr);
        check("wdata", bus_wdata, we ? model_wdata(f3, wdata) : 32'h0);
      end else begin
        check("bus_quiet", bus_addr_in | bus_addr_out | bus_wdata |
              32'(bus_size_in) | 32'(bus_size_out), 32'h0);
      end
      @(posedge clk); #1;
    end
    check("resp_cycle", 32'(resp_cyc), 32'(resp_exp));
    check("strobe_cycle", 32'(strobe_cyc), 32'(strobe_exp));
    check("strobe_count", 32'(nstrobe), (e == 2'b00) ? 32'd1 : 32'd0);
    set_bus(1'b0, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0; req_addr = 32'h0; req_wdata = 32'h0;
    bus_rdata = 32'h0; bus_ready = 1'b1; bus_busy = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_strobes", 32'({bus_wd, bus_rd}), 32'd0);
    check("rst_bus", bus_addr_in | bus_addr_out | bus_wdata, 32'h0);
    rst = 1'b0;

    // idle-bus loads, stores, extension
    do_req(1'b0, 3'd2, 32'h0000_0010, 32'h0, 32'h8123_4567, 0, 1'b0);  // LW
    do_req(1'b0, 3'd0, 32'h0000_0013, 32'h0, 32'h0000_0080, 0, 1'b0);  // LB
    do_req(1'b0, 3'd4, 32'h0000_0013, 32'h0, 32'h0000_0080, 0, 1'b0);  // LBU
    do_req(1'b1, 3'd1, 32'h0000_0022, 32'hDEAD_BEEF, 32'h0, 0, 1'b0);  // SH
    do_req(1'b0, 3'd1, 32'h0000_0002, 32'h0, 32'h1234_8001, 0, 1'b0);  // LH
    do_req(1'b0, 3'd5, 32'h0000_0002, 32'h0, 32'h1234_8001, 0, 1'b0);  // LHU
    do_req(1'b1, 3'd0, 32'h0000_0001, 32'h1234_5678, 32'h0, 0, 1'b0);  // SB
    do_req(1'b1, 3'd2, 32'h0000_0104, 32'hCAFE_F00D, 32'h0, 0, 1'b0);  // SW

    // misaligned and illegal funct3
    do_req(1'b0, 3'd2, 32'h0000_0006, 32'h0, 32'hFFFF_FFFF, 0, 1'b0);  // LW mis
    do_req(1'b1, 3'd1, 32'h0000_0003, 32'h5555_5555, 32'h0, 0, 1'b0);  // SH mis
    do_req(1'b0, 3'd3, 32'h0000_0000, 32'h0, 32'h1111_1111, 0, 1'b0);  // load 011
    do_req(1'b0, 3'd7, 32'h0000_0008, 32'h0, 32'h1111_1111, 0, 1'b0);  // load 111
    do_req(1'b1, 3'd4, 32'h0000_0000, 32'h7777_7777, 32'h0, 0, 1'b0);  // store 100

    // bus stalls via busy and via not-ready
    do_req(1'b1, 3'd2, 32'h0000_0200, 32'hA5A5_5A5A, 32'h0, 3, 1'b0);
    do_req(1'b0, 3'd0, 32'h0000_0031, 32'h0, 32'h0000_007F, 5, 1'b1);
    do_req(1'b0, 3'd2, 32'h0000_0040, 32'h0, 32'h0BAD_CAFE, 20, 1'b0);
    do_req(1'b1, 3'd1, 32'h0000_0044, 32'h0000_1234, 32'h0, 15, 1'b1);

    // async reset mid-ISSUE drops the strobe and suppresses the response
    @(posedge clk); #1;
    req_we = 1'b0; req_funct3 = 3'd2; req_addr = 32'h0000_0100; req_valid = 1'b1;
    bus_rdata = 32'h1357_9BDF;
    set_bus(1'b1, 1'b0);
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    set_bus(1'b0, 1'b0);
    #1 check("pre_rst_strobe", 32'(bus_rd), 32'd1);
    rst = 1'b1;
    #1;
    check("midrst_rd", 32'(bus_rd), 32'd0);
    check("midrst_addr", bus_addr_out, 32'h0);
    check("midrst_size", 32'(bus_size_out), 32'd0);
    check("midrst_ready", 32'(req_ready), 32'd1);
    check("midrst_resp", 32'(resp_valid), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    do_req(1'b0, 3'd1, 32'h0000_0102, 32'h0, 32'h0000_F00F, 0, 1'b0);

    repeat (3) @(posedge clk);
    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
